// File: rtl/pattern_player_if.sv
// Playback bus between the pattern source / LED driver and pattern_player.
// The master side issues start/abort with the pattern; the slave side drives the LED stream.
interface pattern_player_if #(
  parameter int PAT_W = 16
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  localparam int IDX_W = $clog2(PAT_W);

  logic             start;
  logic             abort;
  logic [PAT_W-1:0] pattern;
  logic [LEN_W-1:0] length;
  logic             led_valid;
  logic             led_bit;
  logic [IDX_W-1:0] index;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, pattern, length,
    input  led_valid, led_bit, index, busy, done
  );

  modport slave (
    input  start, abort, pattern, length,
    output led_valid, led_bit, index, busy, done
  );
endinterface

// File: rtl/pattern_player.sv
// Plays a latched pattern MSB-first as SHOW/GAP phases, then pulses done.
// Define PATTERN_PLAYER_SPEEDUP_EN to shorten the on-time as the pattern grows.
module pattern_player #(
  parameter int PAT_W      = 16,
  parameter int ON_CYCLES  = 4,
  parameter int GAP_CYCLES = 2,
  parameter int MIN_ON     = 2
) (
  input  logic            clk,
  input  logic            rst,
  pattern_player_if.slave bus
);
  localparam int LEN_W   = $clog2(PAT_W + 1);
  localparam int IDX_W   = $clog2(PAT_W);
  localparam int CNT_MAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  if (ON_CYCLES < 1 || GAP_CYCLES < 1 || MIN_ON < 1 || MIN_ON > ON_CYCLES) begin : g_bad_cfg
    $error("pattern_player: invalid timing parameters");
  end

  typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

  state_t           state_q, state_d;
  logic [PAT_W-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [LEN_W-1:0] len_clamp;
  logic [CNT_W-1:0] start_on;  // on-time of the first element
  logic [CNT_W-1:0] on_load;   // on-time of every later element

  assign len_clamp = (bus.length > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.length;

`ifdef PATTERN_PLAYER_SPEEDUP_EN
  logic [CNT_W-1:0] t_on_q, t_on_d;

  function automatic logic [CNT_W-1:0] speed_on(input logic [LEN_W-1:0] l);
    int shifted;
    shifted = ON_CYCLES >> (int'(l) >> 2);
    return CNT_W'((shifted < MIN_ON) ? MIN_ON : shifted);
  endfunction

  assign start_on = speed_on(len_clamp);
  assign on_load  = t_on_q;
`else
  assign start_on = CNT_W'(ON_CYCLES);
  assign on_load  = CNT_W'(ON_CYCLES);
`endif

  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
    t_on_d   = t_on_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            shadow_d = bus.pattern;
            if (len_clamp == '0) begin
              state_d = DONE;
            end else begin
              state_d = SHOW;
              idx_d   = IDX_W'(len_clamp - LEN_W'(1));
              cnt_d   = start_on;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
              t_on_d  = start_on;
`endif
            end
          end
        end
        SHOW: begin
          if (cnt_q <= CNT_W'(1)) begin
            state_d = GAP;
            cnt_d   = CNT_W'(GAP_CYCLES);
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_q > CNT_W'(1)) begin
            cnt_d = cnt_q - CNT_W'(1);
          end else if (idx_q == '0) begin
            state_d = DONE;
            cnt_d   = '0;
          end else begin
            state_d = SHOW;
            idx_d   = idx_q - IDX_W'(1);
            cnt_d   = on_load;
          end
        end
        DONE: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: the shadow pattern is ordinary flops, not RAM, so it is cleared with the rest.
    if (rst) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
      t_on_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
`ifdef PATTERN_PLAYER_SPEEDUP_EN
      t_on_q   <= t_on_d;
`endif
    end
  end

  assign bus.led_valid = (state_q == SHOW);
  assign bus.led_bit   = (state_q == SHOW) & shadow_q[idx_q];
  assign bus.index     = idx_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
endmodule
